// File: rtl/mem_port_master.sv
// Requester endpoint for one port of the shared-RAM controller: takes one client command,
// drives the port until ack, returns a response. Optional timeout: MEM_PORT_MASTER_TIMEOUT_EN.
module mem_port_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_di,
    output logic              mem_we,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_do
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;
    logic   load_cmd;
    logic   capture;
    logic   expire;

`ifdef MEM_PORT_MASTER_TIMEOUT_EN
    localparam logic [7:0] EXPIRE_COUNT = 8'(TIMEOUT - 1);

    logic [7:0] req_count;
    logic       rsp_err_q;

    // An ack arriving in the expiry cycle still wins, so expiry requires ack low.
    assign expire  = (state == REQ) && !mem_ack && (req_count == EXPIRE_COUNT);
    assign rsp_err = rsp_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_count <= 8'd0;
            rsp_err_q <= 1'b0;
        end else begin
            if (load_cmd) begin
                req_count <= 8'd0;
            end else if (state == REQ && !mem_ack) begin
                req_count <= req_count + 8'd1;
            end
            if (capture) begin
                rsp_err_q <= 1'b0;
            end else if (expire) begin
                rsp_err_q <= 1'b1;
            end
        end
    end
`else
    assign expire  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // mem_en is gated by ack combinationally: the controller resamples enables in the
    // ack cycle and would otherwise perform a second access.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_en     = 1'b0;
        load_cmd   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    load_cmd   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_en = !mem_ack;
                if (mem_ack) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else if (expire) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_di   <= '0;
            rsp_data <= '0;
        end else begin
            if (load_cmd) begin
                mem_we   <= cmd_we;
                mem_addr <= cmd_addr;
                mem_di   <= cmd_data;
            end
            if (capture) begin
                rsp_data <= mem_we ? '0 : mem_do;
            end else if (expire) begin
                rsp_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_master.sv
// Self-checking bench for mem_port_master: the bench plays the RAM controller, keeping
// its own memory array as the reference model, and checks the client/port handshakes.
module tb_mem_port_master;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       mem_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_di;
    logic       mem_we;
    logic       mem_ack;
    logic [7:0] mem_do;

    int         n_checks;
    int         n_fail;
    logic [7:0] ref_mem [256];

    mem_port_master #(
        .ADDR_W (8),
        .DATA_W (8),
        .TIMEOUT(15)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_di   (mem_di),
        .mem_we   (mem_we),
        .mem_ack  (mem_ack),
        .mem_do   (mem_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // One complete transaction; ack arrives ack_delay cycles after mem_en first rises.
    task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [7:0] data,
                                 input int ack_delay, input int ready_delay, input logic spurious);
        logic [7:0] exp_data;
        logic [7:0] ram_word;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_data  = data;
        #1 checkBit("cmd_ready_idle", cmd_ready, 1'b1);
        stepCycle();
        cmd_valid = 1'b0;
        cmd_we    = ~we;
        cmd_addr  = 8'($urandom);
        cmd_data  = 8'($urandom);
        #1;
        checkBit("mem_en_req", mem_en, 1'b1);
        checkOutput("mem_addr", mem_addr, addr);
        checkBit("mem_we", mem_we, we);
        if (we) checkOutput("mem_di", mem_di, data);
        checkBit("cmd_ready_busy", cmd_ready, 1'b0);
        for (int i = 1; i < ack_delay; i++) begin
            stepCycle();
            #1;
            checkBit("mem_en_wait", mem_en, 1'b1);
            checkOutput("mem_addr_hold", mem_addr, addr);
        end
        stepCycle();
        ram_word = ref_mem[addr];
        exp_data = we ? 8'h00 : ram_word;
        if (we) ref_mem[addr] = data;
        mem_ack = 1'b1;
        mem_do  = we ? 8'($urandom) : ram_word;
        #1;
        checkBit("mem_en_ack_gate", mem_en, 1'b0);
        checkBit("rsp_valid_early", rsp_valid, 1'b0);
        stepCycle();
        mem_ack = 1'b0;
        mem_do  = 8'($urandom);
        #1;
        checkBit("rsp_valid", rsp_valid, 1'b1);
        checkOutput("rsp_data", rsp_data, exp_data);
        checkBit("rsp_err", rsp_err, 1'b0);
        checkBit("mem_en_resp", mem_en, 1'b0);
        for (int i = 0; i < ready_delay; i++) begin
            rsp_ready = 1'b0;
            if (spurious && i == 0) begin
                mem_ack = 1'b1;
                mem_do  = 8'hFF;
            end
            stepCycle();
            mem_ack = 1'b0;
            #1;
            checkBit("rsp_valid_hold", rsp_valid, 1'b1);
            checkOutput("rsp_data_hold", rsp_data, exp_data);
            checkBit("cmd_ready_resp", cmd_ready, 1'b0);
        end
        // A command offered in the handshake cycle must not be taken.
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = ~addr;
        stepCycle();
        rsp_ready = 1'b0;
        #1;
        checkBit("rsp_valid_done", rsp_valid, 1'b0);
        checkBit("cmd_ready_back", cmd_ready, 1'b1);
        checkBit("mem_en_no_accept", mem_en, 1'b0);
        cmd_valid = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 8'h00;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;
        mem_ack   = 1'b0;
        mem_do    = 8'h00;

        #2;
        checkBit("reset_cmd_ready", cmd_ready, 1'b1);
        checkBit("reset_rsp_valid", rsp_valid, 1'b0);
        checkBit("reset_rsp_err", rsp_err, 1'b0);
        checkOutput("reset_rsp_data", rsp_data, 8'h00);
        checkBit("reset_mem_en", mem_en, 1'b0);
        checkOutput("reset_mem_addr", mem_addr, 8'h00);
        checkOutput("reset_mem_di", mem_di, 8'h00);
        checkBit("reset_mem_we", mem_we, 1'b0);
        stepCycle();
        stepCycle();
        reset = 1'b1;
        stepCycle();

        $display("[TB] write 0x10=0xA5, read back with backpressure and spurious ack");
        applyStimulus(1'b1, 8'h10, 8'hA5, 1, 0, 1'b0);
        applyStimulus(1'b0, 8'h10, 8'h00, 1, 5, 1'b1);

        $display("[TB] contention: ack held off for 6 extra cycles");
        applyStimulus(1'b0, 8'h10, 8'h00, 7, 0, 1'b0);

`ifdef MEM_PORT_MASTER_TIMEOUT_EN
        $display("[TB] timeout with no ack");
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 8'h44;
        stepCycle();
        cmd_valid = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            #1 checkBit("mem_en_before_timeout", mem_en, 1'b1);
            stepCycle();
        end
        stepCycle();
        #1;
        checkBit("timeout_rsp_valid", rsp_valid, 1'b1);
        checkBit("timeout_rsp_err", rsp_err, 1'b1);
        checkOutput("timeout_rsp_data", rsp_data, 8'h00);
        checkBit("timeout_mem_en", mem_en, 1'b0);
        rsp_ready = 1'b1;
        stepCycle();
        rsp_ready = 1'b0;
        #1 checkBit("timeout_done", rsp_valid, 1'b0);
`else
        $display("[TB] long wait without ack never aborts");
        applyStimulus(1'b0, 8'h10, 8'h00, 40, 0, 1'b0);
`endif
        $display("[TB] ack in the last allowed REQ cycle");
        applyStimulus(1'b0, 8'h10, 8'h00, 14, 1, 1'b0);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 12; n++) begin
            applyStimulus(1'($urandom), 8'h20 + 8'($urandom_range(0, 3)), 8'($urandom),
                          int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("[TB] reset in mid-transaction");
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 8'h33;
        stepCycle();
        cmd_valid = 1'b0;
        #1 checkBit("mid_req_mem_en", mem_en, 1'b1);
        reset = 1'b0;
        #1;
        checkBit("reset_drops_mem_en", mem_en, 1'b0);
        checkBit("reset_cmd_ready_mid", cmd_ready, 1'b1);
        checkOutput("reset_mem_addr_mid", mem_addr, 8'h00);
        for (int i = 0; i < 3; i++) begin
            mem_ack = (i == 1);
            stepCycle();
            #1 checkBit("reset_no_rsp", rsp_valid, 1'b0);
        end
        mem_ack = 1'b0;
        reset   = 1'b1;
        stepCycle();
        #1 checkBit("after_reset_no_rsp", rsp_valid, 1'b0);
        applyStimulus(1'b0, 8'h10, 8'h00, 1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
